// File: rtl/keyb_debounce_multi.sv
// Multi-channel key debouncer: 2-flop synchroniser, per-channel stable-count filter, press/release pulses.
// Optional auto-repeat on held keys is compiled in with `define KEYB_AUTOREPEAT_EN.
module keyb_debounce_multi #(
  parameter int N_CH       = 4,
  parameter int DEB_CYCLES = 50000,
  parameter int CNT_W      = $clog2(DEB_CYCLES + 1),
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       btn_press_in,
  output logic [N_CH-1:0]       level,
  output logic [N_CH-1:0]       enable,
  output logic [N_CH-1:0]       release_o,
  output logic                  any_enable,
  output logic [N_CH*CNT_W-1:0] dbg_cnt
);

  if (N_CH < 1 || N_CH > 32 || DEB_CYCLES < 2 || CNT_W < $clog2(DEB_CYCLES) ||
      REP_DELAY < 1 || REP_PERIOD < 1) begin : g_param_check
    $error("keyb_debounce_multi: illegal parameter value");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [N_CH-1:0]  sync1_q, sync2_q;
  logic [N_CH-1:0]  level_q, level_d;
  logic [N_CH-1:0]  enable_q, release_q;
  logic [N_CH-1:0]  rise, fall, rep_fire;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  // Count only while the synchronised input disagrees with the accepted level;
  // any agreement (a glitch ending) restarts the count from zero.
  always_comb begin
    level_d = level_q;
    rise    = '0;
    fall    = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync2_q[i];
          rise[i]    = sync2_q[i];
          fall[i]    = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      enable_q  <= '0;
      release_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn_press_in;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      enable_q  <= rise | rep_fire;
      release_q <= fall;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef KEYB_AUTOREPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY_M1 = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER_M1 = REP_W'(REP_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q [N_CH];
  logic [REP_W-1:0] rep_cnt_d [N_CH];
  logic [N_CH-1:0]  rep_first_q, rep_first_d;

  // rep_first selects the initial long delay; afterwards the shorter period applies.
  always_comb begin
    rep_fire    = '0;
    rep_first_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      rep_cnt_d[i] = '0;
      if (rise[i]) begin
        rep_first_d[i] = 1'b1;
      end else if (level_q[i] && !fall[i]) begin
        if ((rep_first_q[i] && rep_cnt_q[i] == REP_DLY_M1) ||
            (!rep_first_q[i] && rep_cnt_q[i] == REP_PER_M1)) begin
          rep_fire[i] = 1'b1;
        end else begin
          rep_cnt_d[i]   = rep_cnt_q[i] + REP_W'(1);
          rep_first_d[i] = rep_first_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_first_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        rep_cnt_q[i] <= '0;
      end
    end else begin
      rep_first_q <= rep_first_d;
      for (int i = 0; i < N_CH; i++) begin
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end
`else
  assign rep_fire = '0;
`endif

  always_comb begin
    dbg_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      dbg_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign level      = level_q;
  assign enable     = enable_q;
  assign release_o  = release_q;
  assign any_enable = |enable_q;

endmodule

// File: tb/tb_keyb_debounce_multi.sv
// Directed bench for keyb_debounce_multi (N_CH=4, DEB_CYCLES=16, REP_DELAY=100, REP_PERIOD=40).
module tb_keyb_debounce_multi;

  localparam int N_CH  = 4;
  localparam int DEB   = 16;
  localparam int CNT_W = 5;
  localparam int LAT   = DEB + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_CH-1:0]   btn_press_in;
  logic [N_CH-1:0]   level, enable, release_o;
  logic              any_enable;
  logic [N_CH*CNT_W-1:0] dbg_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int en_cnt [N_CH];
  int rel_cnt [N_CH];

  keyb_debounce_multi #(
    .N_CH(N_CH), .DEB_CYCLES(DEB), .CNT_W(CNT_W), .REP_DELAY(100), .REP_PERIOD(40)
  ) dut (
    .clk(clk), .reset(reset), .btn_press_in(btn_press_in), .level(level),
    .enable(enable), .release_o(release_o), .any_enable(any_enable), .dbg_cnt(dbg_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      en_cnt[i]  = 0;
      rel_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      en_cnt[i]  += int'(enable[i]);
      rel_cnt[i] += int'(release_o[i]);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int bad;
    logic [3:0] vec [10];
    vec = '{4'hF, 4'h0, 4'hA, 4'h5, 4'hF, 4'hF, 4'h3, 4'hC, 4'h9, 4'h6};
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      btn_press_in = vec[k];
      step(1);
      if (level !== 0 || enable !== 0 || release_o !== 0 || any_enable !== 0 || dbg_cnt !== 0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL reset_hold: %0d cycles with nonzero outputs, required 0", bad);
    end
    btn_press_in = '0;
    reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (level !== 0 || enable !== 0 || release_o !== 0 || any_enable !== 0 || dbg_cnt !== 0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL reset_idle: %0d cycles with nonzero outputs, required 0", bad);
    end
  endtask

  task automatic test_bounce();
    int bad, e0;
    logic bnc [13];
    bnc = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    e0 = en_cnt[0];
    bad = 0;
    for (int k = 0; k < 13; k++) begin
      btn_press_in[0] = bnc[k];
      step(1);
      if (level[0] !== 1'b0 || enable !== 0) bad++;
    end
    btn_press_in[0] = 1'b1;
    for (int k = 1; k < LAT; k++) begin
      step(1);
      if (level[0] !== 1'b0 || enable !== 0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL bounce_quiet: %0d early level/enable cycles, required 0", bad);
    end
    step(1);
    tests_run++;
    if (level[0] !== 1'b1 || enable !== 4'b0001 || any_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL bounce_press: level=%b enable=%b any=%b, required 1 0001 1", level[0], enable, any_enable);
    end
    step(1);
    tests_run++;
    if (enable !== 4'b0000 || level[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL bounce_pulse_width: enable=%b level0=%b, required 0000 1", enable, level[0]);
    end
    step(5);
    tests_run++;
    if (en_cnt[0] - e0 != 1) begin
      tests_failed++;
      $display("FAIL bounce_count: %0d enable[0] pulses, required 1", en_cnt[0] - e0);
    end
  endtask

  task automatic test_glitch();
    int bad, r1;
    btn_press_in[1] = 1'b1;
    step(LAT);
    tests_run++;
    if (level[1] !== 1'b1 || enable !== 4'b0010) begin
      tests_failed++;
      $display("FAIL glitch_press: level1=%b enable=%b, required 1 0010", level[1], enable);
    end
    step(5);
    r1 = rel_cnt[1];
    btn_press_in[1] = 1'b0;
    step(5);
    btn_press_in[1] = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (level[1] !== 1'b1 || release_o !== 0) bad++;
    end
    tests_run++;
    if (bad != 0 || rel_cnt[1] != r1) begin
      tests_failed++;
      $display("FAIL glitch_ignored: %0d bad cycles, %0d releases, required 0 0", bad, rel_cnt[1] - r1);
    end
    btn_press_in[1] = 1'b0;
    bad = 0;
    for (int k = 1; k < LAT; k++) begin
      step(1);
      if (level[1] !== 1'b1 || release_o !== 0) bad++;
    end
    step(1);
    tests_run++;
    if (bad != 0 || level[1] !== 1'b0 || release_o !== 4'b0010 || enable !== 0) begin
      tests_failed++;
      $display("FAIL glitch_release: early=%0d level1=%b release=%b enable=%b, required 0 0 0010 0000",
               bad, level[1], release_o, enable);
    end
    step(1);
    tests_run++;
    if (release_o !== 0 || rel_cnt[1] - r1 != 1) begin
      tests_failed++;
      $display("FAIL glitch_release_once: release=%b count=%0d, required 0000 1", release_o, rel_cnt[1] - r1);
    end
  endtask

  task automatic test_simultaneous();
    int bad;
    btn_press_in[0] = 1'b0;
    step(LAT);
    tests_run++;
    if (release_o !== 4'b0001 || level !== 4'b0000) begin
      tests_failed++;
      $display("FAIL ch0_release: release=%b level=%b, required 0001 0000", release_o, level);
    end
    step(4);
    btn_press_in = 4'b1001;
    bad = 0;
    for (int k = 1; k < LAT; k++) begin
      step(1);
      if (any_enable !== 1'b0 || enable !== 0) bad++;
    end
    step(1);
    tests_run++;
    if (bad != 0 || enable !== 4'b1001 || any_enable !== 1'b1 || level !== 4'b1001) begin
      tests_failed++;
      $display("FAIL simul_press: early=%0d enable=%b any=%b level=%b, required 0 1001 1 1001",
               bad, enable, any_enable, level);
    end
    step(1);
    tests_run++;
    if (enable !== 4'b0000 || any_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_after: enable=%b any=%b, required 0000 0", enable, any_enable);
    end
    btn_press_in = 4'b0000;
    step(LAT);
    tests_run++;
    if (release_o !== 4'b1001 || enable !== 4'b0000) begin
      tests_failed++;
      $display("FAIL simul_release: release=%b enable=%b, required 1001 0000", release_o, enable);
    end
    step(3);
  endtask

  task automatic test_reset_mid();
    int bad, e2;
    btn_press_in[2] = 1'b1;
    step(12);
    tests_run++;
    if (dbg_cnt[14:10] !== 5'd10) begin
      tests_failed++;
      $display("FAIL mid_count: cnt2=%0d, required 10", dbg_cnt[14:10]);
    end
    e2 = en_cnt[2];
    reset = 1'b0;
    #1;
    tests_run++;
    if (dbg_cnt !== 0 || level !== 0 || enable !== 0) begin
      tests_failed++;
      $display("FAIL mid_reset_clear: cnt=%h level=%b enable=%b, required 0 0 0", dbg_cnt, level, enable);
    end
    step(3);
    reset = 1'b1;
    bad = 0;
    for (int k = 1; k < LAT; k++) begin
      step(1);
      if (enable !== 0 || level[2] !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0 || en_cnt[2] != e2) begin
      tests_failed++;
      $display("FAIL mid_no_pulse: %0d bad cycles, %0d pulses, required 0 0", bad, en_cnt[2] - e2);
    end
    step(1);
    tests_run++;
    if (enable !== 4'b0100 || level[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_repress: enable=%b level2=%b, required 0100 1", enable, level[2]);
    end
    btn_press_in[2] = 1'b0;
    step(LAT);
    tests_run++;
    if (release_o !== 4'b0100) begin
      tests_failed++;
      $display("FAIL mid_release: release=%b, required 0100", release_o);
    end
    step(3);
  endtask

  task automatic test_autorepeat();
    int bad, first_bad, e0;
    logic exp_en;
    e0 = en_cnt[0];
    btn_press_in[0] = 1'b1;
    step(LAT);
    tests_run++;
    if (enable !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rep_press: enable=%b, required 0001", enable);
    end
    bad = 0;
    first_bad = -1;
    for (int k = 1; k < 317; k++) begin
      if (k == 300) btn_press_in[0] = 1'b0;
      step(1);
`ifdef KEYB_AUTOREPEAT_EN
      exp_en = (k >= 100) && ((k - 100) % 40 == 0);
`else
      exp_en = 1'b0;
`endif
      if (enable !== {3'b000, exp_en} || any_enable !== exp_en || level[0] !== 1'b1) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL rep_pattern: %0d bad cycles, first at press+%0d, required 0", bad, first_bad);
    end
    step(1);
    tests_run++;
    if (release_o !== 4'b0001 || enable !== 4'b0000 || level[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rep_release: release=%b enable=%b level0=%b, required 0001 0000 0",
               release_o, enable, level[0]);
    end
    step(5);
    tests_run++;
`ifdef KEYB_AUTOREPEAT_EN
    if (en_cnt[0] - e0 != 7) begin
      tests_failed++;
      $display("FAIL rep_count: %0d enable[0] pulses, required 7", en_cnt[0] - e0);
    end
`else
    if (en_cnt[0] - e0 != 1) begin
      tests_failed++;
      $display("FAIL rep_count: %0d enable[0] pulses, required 1", en_cnt[0] - e0);
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    btn_press_in = '0;
    test_reset();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_autorepeat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
